// File: rtl/gpio_filt_pkg.sv
// -----------------------------------------------------------------------------
// gpio_filt_pkg
// Shared constants for the GPIO input conditioning stage.
//   DefaultDebounce : threshold used where debounce_cycles_i is tied off
//                     at SoC level (1000 cycles of stable input).
//   GpioWidth       : number of GPIO bits in the SoC.
//   eff_threshold() : the threshold the counter actually has to reach.
//                     A programmed value of 0 acts like 1, because an
//                     input change always takes at least one edge to be
//                     accepted.
// -----------------------------------------------------------------------------
package gpio_filt_pkg;

    localparam logic [15:0] DefaultDebounce = 16'd1000;
    localparam int          GpioWidth       = 32;

    // Effective threshold for a counter of cnt_w bits, widened by one bit so
    // that the comparison against cnt_q + 1 can never wrap.
    function automatic logic [16:0] eff_threshold(input logic [15:0] n);
        logic [16:0] t;
        t = {1'b0, n};
        if (n == '0) begin
            t = 17'd1;
        end
        return t;
    endfunction

endpackage : gpio_filt_pkg

// File: rtl/gpio_in_filter_bit.sv
// -----------------------------------------------------------------------------
// gpio_in_filter_bit
// Conditioning for a single GPIO input: metastability synchroniser, debounce
// counter, accepted-value flop and a one-cycle-delayed copy for edge pulses.
//
// Ports
//   clk_i              system clock
//   rst_ni             asynchronous active-low reset (all flops clear to 0)
//   pad_i              raw asynchronous pad input
//   filt_en_i          1 = debounce, 0 = synchronise only
//   debounce_cycles_i  number of consecutive disagreeing cycles needed
//                      before a new level is accepted (0 behaves like 1)
//   gpio_o             conditioned level
//   rise_o             one-cycle pulse when gpio_o goes 0->1
//   fall_o             one-cycle pulse when gpio_o goes 1->0
// -----------------------------------------------------------------------------
module gpio_in_filter_bit #(
    parameter int SyncStages = 2,
    parameter int CntW       = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            pad_i,
    input  logic            filt_en_i,
    input  logic [CntW-1:0] debounce_cycles_i,
    output logic            gpio_o,
    output logic            rise_o,
    output logic            fall_o
);

    // ---------------------------------------------------------------------
    // Synchroniser: a plain shift chain with nothing between stages, so the
    // tool sees a clean flop-to-flop path for metastability settling.
    // ---------------------------------------------------------------------
    logic [SyncStages-1:0] sync_q;
    logic                  sync;

    // NOTE: every flop here, the synchroniser included, resets to a known 0;
    // there is no storage array that would be left unreset on purpose.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples the pre-edge value of its neighbours.
            sync_q <= {sync_q[SyncStages-2:0], pad_i};
        end
    end

    assign sync = sync_q[SyncStages-1];

    // ---------------------------------------------------------------------
    // Debounce. cnt_q counts consecutive edges at which the synchronised
    // input disagreed with the accepted level. The increment and compare
    // are done one bit wider than the counter so the test never wraps; the
    // counter is cleared on reaching the threshold, so it never saturates.
    // The threshold is read live, so lowering it mid-count takes effect on
    // the very next edge without restarting.
    // ---------------------------------------------------------------------
    logic            stable_q, stable_d;
    logic            prev_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW:0]   cnt_inc;
    logic [CntW:0]   threshold;
    logic            reached;

    assign cnt_inc   = {1'b0, cnt_q} + {{CntW{1'b0}}, 1'b1};
    assign threshold = {1'b0, debounce_cycles_i};
    // A threshold of 0 is always met, which gives the same one-edge
    // acceptance as a threshold of 1.
    assign reached   = (cnt_inc >= threshold);

    always_comb begin
        // NOTE: defaults first, so every path assigns both outputs and no
        // latch can be inferred.
        stable_d = stable_q;
        cnt_d    = '0;
        if (!filt_en_i) begin
            // Sync-only mode: follow the synchroniser, keep the counter idle
            // so re-enabling starts a fresh count.
            stable_d = sync;
        end else if (sync != stable_q) begin
            if (reached) begin
                stable_d = sync;
            end else begin
                cnt_d = cnt_inc[CntW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    // Edge pulses come straight from flops, so they are glitch-free and last
    // exactly one cycle; rise and fall are mutually exclusive by construction.
    assign gpio_o = stable_q;
    assign rise_o = stable_q & ~prev_q;
    assign fall_o = ~stable_q & prev_q;

endmodule : gpio_in_filter_bit

// File: rtl/gpio_in_filter.sv
// -----------------------------------------------------------------------------
// gpio_in_filter
// Input conditioning in front of the gpio block: each pad bit is synchronised,
// optionally debounced and presented on gpio_o (to gpio cio_gpio_i), together
// with one-cycle rise/fall pulses for wake/event logic. Bits are independent;
// only the debounce threshold is shared.
//
// Parameters
//   Width       number of GPIO bits
//   SyncStages  synchroniser depth, 2 or 3
//   CntW        debounce counter / threshold width
//
// Ports
//   clk_i              system clock
//   rst_ni             asynchronous active-low reset
//   pad_i              raw pad inputs
//   filt_en_i          per-bit debounce enable
//   debounce_cycles_i  shared stable-cycle threshold (live, may change)
//   gpio_o             conditioned inputs
//   rise_o             per-bit 0->1 pulses
//   fall_o             per-bit 1->0 pulses
// -----------------------------------------------------------------------------
module gpio_in_filter
    import gpio_filt_pkg::*;
#(
    parameter int Width      = GpioWidth,
    parameter int SyncStages = 2,
    parameter int CntW       = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] pad_i,
    input  logic [Width-1:0] filt_en_i,
    input  logic [CntW-1:0]  debounce_cycles_i,
    output logic [Width-1:0] gpio_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o
);

    for (genvar b = 0; b < Width; b++) begin : g_bit
        gpio_in_filter_bit #(
            .SyncStages (SyncStages),
            .CntW       (CntW)
        ) u_bit (
            .clk_i             (clk_i),
            .rst_ni            (rst_ni),
            .pad_i             (pad_i[b]),
            .filt_en_i         (filt_en_i[b]),
            .debounce_cycles_i (debounce_cycles_i),
            .gpio_o            (gpio_o[b]),
            .rise_o            (rise_o[b]),
            .fall_o            (fall_o[b])
        );
    end

endmodule : gpio_in_filter

// File: tb/tb_gpio_in_filter.sv
// -----------------------------------------------------------------------------
// tb_gpio_in_filter
// Scoreboard bench: a reference model on the clock edge turns the applied
// inputs into the expected outputs and queues them; a monitor on the opposite
// edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_gpio_in_filter;

    localparam int W  = 32;
    localparam int SS = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b1;
    logic [W-1:0]  pad_i = '0;
    logic [W-1:0]  filt_en_i = '0;
    logic [CW-1:0] debounce_cycles_i = 16'd1;
    logic [W-1:0]  gpio_o, rise_o, fall_o;

    gpio_in_filter #(.Width(W), .SyncStages(SS), .CntW(CW)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .pad_i             (pad_i),
        .filt_en_i         (filt_en_i),
        .debounce_cycles_i (debounce_cycles_i),
        .gpio_o            (gpio_o),
        .rise_o            (rise_o),
        .fall_o            (fall_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model. The synchroniser is a FIFO of pad samples SS deep;
    // each bit's filter remembers how many edges in a row the synchronised
    // value has disagreed with the accepted one, and accepts it once that
    // run reaches max(N,1) edges under the live N.
    // ---------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] g;
        logic [W-1:0] r;
        logic [W-1:0] f;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] m_pipe[$];
    logic [W-1:0] m_stable, m_prev, m_sync;
    int           m_run[W];
    int           m_thr;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_stable = '0;
            m_prev   = '0;
            for (int b = 0; b < W; b++) m_run[b] = 0;
            m_pipe.delete();
            for (int i = 0; i < SS; i++) m_pipe.push_back('0);
            exp_q.delete();
        end else begin
            m_sync = m_pipe.pop_front();
            m_pipe.push_back(pad_i);
            m_prev = m_stable;
            m_thr  = (debounce_cycles_i == 0) ? 1 : int'(debounce_cycles_i);
            for (int b = 0; b < W; b++) begin
                if (!filt_en_i[b]) begin
                    m_stable[b] = m_sync[b];
                    m_run[b]    = 0;
                end else if (m_sync[b] == m_prev[b]) begin
                    m_run[b] = 0;
                end else begin
                    m_run[b] = m_run[b] + 1;
                    if (m_run[b] >= m_thr) begin
                        m_stable[b] = m_sync[b];
                        m_run[b]    = 0;
                    end
                end
            end
            exp_q.push_back('{m_stable, m_stable & ~m_prev, ~m_stable & m_prev});
        end
    end

    // Monitor
    exp_t e;
    always @(negedge clk) begin
        if (rst_ni && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("gpio_o", gpio_o, e.g);
            check("rise_o", rise_o, e.r);
            check("fall_o", fall_o, e.f);
            check("rise_and_fall_together", rise_o & fall_o, '0);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers
    // ---------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive a fixed pulse train on bit 7 and record its output triple.
    logic [2:0] rec_n0[20];
    logic [2:0] rec_n1[20];
    task automatic run_bit7(input logic [CW-1:0] n, output logic [2:0] rec[20]);
        int pat[20];
        pat = '{0,1,1,1,0,1,1,0,0,0,1,0,1,0,0,0,0,0,0,0};
        debounce_cycles_i = n;
        pad_i[7] = 1'b0;
        tick(8);
        for (int i = 0; i < 20; i++) begin
            pad_i[7] = pat[i][0];
            @(negedge clk);
            rec[i] = {gpio_o[7], rise_o[7], fall_o[7]};
        end
    endtask

    initial begin
        // Power-on reset with all pads high and filtering off.
        pad_i     = '1;
        filt_en_i = '0;
        #1 rst_ni = 1'b0;
        #1;
        check("reset_gpio", gpio_o, '0);
        check("reset_rise", rise_o, '0);
        check("reset_fall", fall_o, '0);
        tick(2);
        rst_ni = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("release_gpio_edge3", gpio_o, '1);
        check("release_rise_edge3", rise_o, '1);
        @(posedge clk);
        #1;
        check("release_rise_one_cycle", rise_o, '0);

        // Filtered bits 0, 3, 7, 9; clear everything low first.
        tick(1);
        pad_i             = '0;
        filt_en_i         = 32'h0000_0289;
        debounce_cycles_i = 16'd5;
        tick(12);

        // Bit 0: clean rise with N = 5.
        pad_i[0] = 1'b1;
        tick(12);

        // Bit 3: three 4-cycle glitches with 2-cycle gaps never pass.
        repeat (3) begin
            pad_i[3] = 1'b1;
            tick(4);
            pad_i[3] = 1'b0;
            tick(2);
        end
        tick(8);

        // Bit 7: N = 0 and N = 1 produce the same waveform.
        run_bit7(16'd0, rec_n0);
        run_bit7(16'd1, rec_n1);
        for (int i = 0; i < 20; i++) check("n0_vs_n1_bit7", W'(rec_n0[i]), W'(rec_n1[i]));

        // Bit 9: long threshold lowered mid-count.
        debounce_cycles_i = 16'd100;
        tick(4);
        pad_i[9] = 1'b1;
        tick(SS + 40);
        debounce_cycles_i = 16'd10;
        tick(5);

        // Asynchronous reset between edges clears outputs at once.
        pad_i = '1;
        filt_en_i = '0;
        tick(4);
        @(posedge clk);
        #2 rst_ni = 1'b0;
        #1;
        check("async_reset_gpio", gpio_o, '0);
        check("async_reset_rise", rise_o, '0);
        check("async_reset_fall", fall_o, '0);
        tick(2);
        rst_ni = 1'b1;
        tick(6);

        // Random pad noise, enables and thresholds.
        for (int c = 0; c < 20000; c++) begin
            if ($urandom_range(0, 7) == 0) pad_i = pad_i ^ ($urandom() & $urandom());
            else pad_i = pad_i ^ ($urandom() & $urandom() & $urandom() & $urandom());
            if ($urandom_range(0, 199) == 0) filt_en_i = $urandom();
            if ($urandom_range(0, 149) == 0) debounce_cycles_i = CW'($urandom_range(0, 6));
            if ($urandom_range(0, 4999) == 0) begin
                @(posedge clk);
                #3 rst_ni = 1'b0;
                #1;
                check("rand_reset_gpio", gpio_o, '0);
                tick(1);
                rst_ni = 1'b1;
            end
            tick(1);
        end

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_gpio_in_filter
